ahb3lite_master: RTL

AHB3LITE_MASTER -- requirements
Module: ahb3lite_master

---
 rtl/ahb3lite_pkg.sv | 24 ++
 rtl/ahb3lite_master.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the master's transfer-tracking state type.
package ahb3lite_pkg;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2
  } ahb_state_e;

endpackage

// File: rtl/ahb3lite_master.sv
// Single-transfer AHB3-Lite master: one command in, one NONSEQ out, one response
// back, with address/data pipelining and replay of an address phase cancelled by ERROR.
module ahb3lite_master
  import ahb3lite_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,

  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [AHB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]                cmd_size,
  input  logic [AHB_DATA_WIDTH-1:0] cmd_wdata,

  output logic                      rsp_valid,
  output logic [AHB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,

  output logic [AHB_ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]                HTRANS,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  output logic [3:0]                HPROT,
  output logic                      HMASTLOCK,
  output logic [AHB_DATA_WIDTH-1:0] HWDATA,

  input  logic [AHB_DATA_WIDTH-1:0] HRDATA,
  input  logic                      HREADY,
  input  logic                      HRESP
);

  ahb_state_e                r_state;
  logic [AHB_DATA_WIDTH-1:0] r_ap_wdata;
  logic                      r_dp_write;

  logic                      r_slot_vld;
  logic [AHB_ADDR_WIDTH-1:0] r_slot_addr;
  logic                      r_slot_write;
  logic [2:0]                r_slot_size;
  logic [AHB_DATA_WIDTH-1:0] r_slot_wdata;
  logic                      r_redrive;

  logic w_err_pending;
  logic w_retry_pending;
  logic w_accept;
  logic w_sample;
  logic w_complete;
  logic w_cancel;

  assign w_err_pending   = (r_state == ST_ERR1);
  assign w_retry_pending = r_slot_vld | r_redrive;
  assign cmd_ready       = HRESETn & HREADY & ~w_err_pending & ~w_retry_pending;
  assign w_accept        = cmd_valid & cmd_ready;
  assign w_sample        = HREADY & (HTRANS == HTRANS_NONSEQ) & ~w_err_pending;
  assign w_complete      = HREADY & (r_state != ST_IDLE);
  assign w_cancel        = (r_state == ST_DATA) & ~HREADY & (HRESP == HRESP_ERROR);

  always_ff @(posedge HCLK) begin
    HBURST    <= HBURST_SINGLE;
    HPROT     <= HPROT_DATA_PRIV;
    HMASTLOCK <= 1'b0;
    if (!HRESETn) begin
      r_state      <= ST_IDLE;
      HTRANS       <= HTRANS_IDLE;
      HADDR        <= '0;
      HWRITE       <= 1'b0;
      HSIZE        <= HSIZE_WORD;
      HWDATA       <= '0;
      r_ap_wdata   <= '0;
      r_dp_write   <= 1'b0;
      r_slot_vld   <= 1'b0;
      r_slot_addr  <= '0;
      r_slot_write <= 1'b0;
      r_slot_size  <= HSIZE_WORD;
      r_slot_wdata <= '0;
      r_redrive    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      rsp_valid <= w_complete;
      if (w_complete) begin
        rsp_err   <= w_err_pending | (HRESP == HRESP_ERROR);
        rsp_rdata <= r_dp_write ? '0 : HRDATA;
      end

      // Address phase: first ERROR cycle parks any pending NONSEQ in the retry slot.
      if (w_cancel) begin
        HTRANS    <= HTRANS_IDLE;
        r_redrive <= 1'b0;
        if (HTRANS == HTRANS_NONSEQ) begin
          r_slot_vld   <= 1'b1;
          r_slot_addr  <= HADDR;
          r_slot_write <= HWRITE;
          r_slot_size  <= HSIZE;
          r_slot_wdata <= r_ap_wdata;
        end
      end else if (w_err_pending) begin
        if (HREADY && r_slot_vld) begin
          HTRANS     <= HTRANS_NONSEQ;
          HADDR      <= r_slot_addr;
          HWRITE     <= r_slot_write;
          HSIZE      <= r_slot_size;
          r_ap_wdata <= r_slot_wdata;
          r_slot_vld <= 1'b0;
          r_redrive  <= 1'b1;
        end
      end else if (HREADY) begin
        r_redrive <= 1'b0;
        if (w_accept) begin
          HTRANS     <= HTRANS_NONSEQ;
          HADDR      <= cmd_addr;
          HWRITE     <= cmd_write;
          HSIZE      <= cmd_size;
          r_ap_wdata <= cmd_wdata;
        end else begin
          HTRANS <= HTRANS_IDLE;
        end
      end

      // Data phase
      if (w_sample) begin
        HWDATA     <= HWRITE ? r_ap_wdata : '0;
        r_dp_write <= HWRITE;
      end

      // A replayed address phase has no data phase yet, so ERR1 always
      // returns to IDLE and the replay is picked up when it is sampled.
      case (r_state)
        ST_IDLE: if (w_sample) r_state <= ST_DATA;
        ST_DATA: begin
          if (w_cancel)    r_state <= ST_ERR1;
          else if (HREADY) r_state <= w_sample ? ST_DATA : ST_IDLE;
        end
        ST_ERR1: if (HREADY) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
